shreg_universal_chain: RTL and testbench



---
 rtl/shreg_universal_chain_pkg.sv | 15 +
 rtl/shreg_universal_chain_if.sv | 24 ++
 rtl/shreg_universal_chain_slice8.sv | 45 ++++
 rtl/shreg_universal_chain.sv | 153 +++++++++++++++
 tb/tb_shreg_universal_chain.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/shreg_universal_chain_pkg.sv
// Shared mode encoding and sizing helpers for the universal shift-register chain.
package shreg_pkg;

  typedef enum logic [1:0] {
    SHREG_HOLD = 2'b00,
    SHREG_SHR  = 2'b01,
    SHREG_SHL  = 2'b10,
    SHREG_LOAD = 2'b11
  } shreg_mode_t;

  function automatic int cnt_width(input int frame);
    return $clog2(frame + 1);
  endfunction

endpackage

// File: rtl/shreg_universal_chain_if.sv
// Control/data bundle of the shift-register chain; PAR exists only with SHREG_PARITY_EN.
interface shreg_universal_chain_if #(
  parameter int WIDTH = 8,
  parameter int TAPW  = 3
);
  logic             CE;
  logic [1:0]       S;
  logic [1:0]       DSR;
  logic [1:0]       DSL;
  logic [WIDTH-1:0] D;
  logic [TAPW-1:0]  TSEL;
  logic [WIDTH-1:0] Q;
  logic             QT;
  logic             FRM;
`ifdef SHREG_PARITY_EN
  logic             PAR;

  modport master (output CE, S, DSR, DSL, D, TSEL, input Q, QT, FRM, PAR);
  modport slave  (input CE, S, DSR, DSL, D, TSEL, output Q, QT, FRM, PAR);
`else
  modport master (output CE, S, DSR, DSL, D, TSEL, input Q, QT, FRM);
  modport slave  (input CE, S, DSR, DSL, D, TSEL, output Q, QT, FRM);
`endif
endinterface

// File: rtl/shreg_universal_chain_slice8.sv
// One 8-bit universal slice (hold / shift right / shift left / load); SIR enters bit 0, SIL enters bit 7.
module shreg_slice8
  import shreg_pkg::*;
(
  input  logic        CP,
  input  logic        MRn,
  input  logic        CE,
  input  shreg_mode_t S,
  input  logic        SIR,
  input  logic        SIL,
  input  logic [7:0]  D,
  output logic [7:0]  Q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  // Next-state selection for the slice contents.
  always_comb begin
    q_d = q_q;
    if (CE) begin
      case (S)
        SHREG_HOLD: q_d = q_q;
        SHREG_SHR:  q_d = {q_q[6:0], SIR};
        SHREG_SHL:  q_d = {SIL, q_q[7:1]};
        SHREG_LOAD: q_d = D;
        default:    q_d = q_q;
      endcase
    end else begin
      q_d = q_q;
    end
  end

  // Slice storage with asynchronous clear.
  always_ff @(posedge CP or negedge MRn) begin
    if (!MRn) begin
      q_q <= 8'h00;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/shreg_universal_chain.sv
// Cascaded universal shift register with tap mux and frame counter.
// Optional parity output enabled by defining SHREG_PARITY_EN.
module shreg_universal_chain
  import shreg_pkg::*;
#(
  parameter int SLICES = 1,
  parameter int TAPW   = 3,
  parameter int FRAME  = 8
) (
  input logic                    CP,
  input logic                    MRn,
  shreg_universal_chain_if.slave bus
);

  localparam int WIDTH = 8 * SLICES;
  localparam int CW    = cnt_width(FRAME);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME - 1);

  shreg_mode_t      mode_s;
  logic             dsr_bit_s;
  logic             dsl_bit_s;
  logic [WIDTH-1:0] q_s;
  logic [SLICES-1:0] sir_s;
  logic [SLICES-1:0] sil_s;
  logic             qt_s;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frm_q, frm_d;

  assign mode_s    = shreg_mode_t'(bus.S);
  assign dsr_bit_s = bus.DSR[1] & bus.DSR[0];
  assign dsl_bit_s = bus.DSL[1] & bus.DSL[0];

  // Each slice's MSB feeds its upper neighbour's bit 0 and its LSB feeds the lower neighbour's bit 7.
  for (genvar g = 0; g < SLICES; g++) begin : g_slice
    if (g == 0) begin : g_first
      assign sir_s[g] = dsr_bit_s;
    end else begin : g_mid_r
      assign sir_s[g] = q_s[8*g-1];
    end
    if (g == SLICES - 1) begin : g_last
      assign sil_s[g] = dsl_bit_s;
    end else begin : g_mid_l
      assign sil_s[g] = q_s[8*(g+1)];
    end

    shreg_slice8 u_slice (
      .CP  (CP),
      .MRn (MRn),
      .CE  (bus.CE),
      .S   (mode_s),
      .SIR (sir_s[g]),
      .SIL (sil_s[g]),
      .D   (bus.D[8*g +: 8]),
      .Q   (q_s[8*g +: 8])
    );
  end

  // Tap mux; indices beyond the register read as zero.
  always_comb begin
    qt_s = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      qt_s = (bus.TSEL == TAPW'(i)) ? q_s[i] : qt_s;
    end
  end

  // Frame counter next state: wraps and pulses FRM on the completing shift.
  always_comb begin
    cnt_d = cnt_q;
    frm_d = frm_q;
    if (bus.CE) begin
      case (mode_s)
        SHREG_SHR, SHREG_SHL: begin
          if (cnt_q == FRAME_LAST) begin
            cnt_d = {CW{1'b0}};
            frm_d = 1'b1;
          end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            frm_d = 1'b0;
          end
        end
        SHREG_LOAD: begin
          cnt_d = {CW{1'b0}};
          frm_d = 1'b0;
        end
        SHREG_HOLD: begin
          cnt_d = cnt_q;
          frm_d = 1'b0;
        end
        default: begin
          cnt_d = cnt_q;
          frm_d = frm_q;
        end
      endcase
    end else begin
      cnt_d = cnt_q;
      frm_d = frm_q;
    end
  end

  // Frame counter and flag registers.
  always_ff @(posedge CP or negedge MRn) begin
    if (!MRn) begin
      cnt_q <= {CW{1'b0}};
      frm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      frm_q <= frm_d;
    end
  end

  assign bus.Q   = q_s;
  assign bus.QT  = qt_s;
  assign bus.FRM = frm_q;

`ifdef SHREG_PARITY_EN
  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic [WIDTH-1:0] q_next_s;
  logic             par_q, par_d;

  // Parity tracks the value the slices are about to capture.
  always_comb begin
    q_next_s = q_s;
    par_d    = par_q;
    if (bus.CE) begin
      case (mode_s)
        SHREG_SHR:  begin q_next_s = {q_s[WIDTH-2:0], dsr_bit_s}; par_d = parity_of(q_next_s); end
        SHREG_SHL:  begin q_next_s = {dsl_bit_s, q_s[WIDTH-1:1]}; par_d = parity_of(q_next_s); end
        SHREG_LOAD: begin q_next_s = bus.D;                       par_d = parity_of(q_next_s); end
        SHREG_HOLD: begin q_next_s = q_s;                         par_d = par_q; end
        default:    begin q_next_s = q_s;                         par_d = par_q; end
      endcase
    end else begin
      q_next_s = q_s;
      par_d    = par_q;
    end
  end

  // Parity register.
  always_ff @(posedge CP or negedge MRn) begin
    if (!MRn) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign bus.PAR = par_q;
`endif

endmodule

// File: tb/tb_shreg_universal_chain.sv
// Directed self-checking bench for shreg_universal_chain (SLICES=2, TAPW=5, FRAME=8).
module tb_shreg_universal_chain;

  logic CP;
  logic MRn;
  int   checks;
  int   errors;

  shreg_universal_chain_if #(.WIDTH(16), .TAPW(5)) bus ();

  shreg_universal_chain #(.SLICES(2), .TAPW(5), .FRAME(8)) dut (
    .CP  (CP),
    .MRn (MRn),
    .bus (bus)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic apply(input logic ce, input logic [1:0] s, input logic [1:0] dsr,
                       input logic [1:0] dsl, input logic [15:0] d);
    bus.CE  = ce;
    bus.S   = s;
    bus.DSR = dsr;
    bus.DSL = dsl;
    bus.D   = d;
    @(posedge CP);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (bus.Q !== 16'h0000) begin errors++; $display("FAIL reset_q: got %h expected %h", bus.Q, 16'h0000); end
    checks++;
    if (bus.FRM !== 1'b0) begin errors++; $display("FAIL reset_frm: got %b expected %b", bus.FRM, 1'b0); end
    #10;
    MRn = 1'b1;
    apply(1'b1, 2'b00, 2'b00, 2'b00, 16'h0000);
    checks++;
    if (bus.Q !== 16'h0000) begin errors++; $display("FAIL reset_hold_q: got %h expected %h", bus.Q, 16'h0000); end
  endtask

  task automatic test_shift_right;
    logic [1:0] dsr_tab [8];
    dsr_tab = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b00, 2'b11};
    apply(1'b1, 2'b11, 2'b00, 2'b00, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 2'b01, dsr_tab[i], 2'b00, 16'hFFFF);
      checks++;
      if (bus.FRM !== (i == 7)) begin
        errors++; $display("FAIL shr_frm_edge%0d: got %b expected %b", i + 1, bus.FRM, (i == 7));
      end
    end
    checks++;
    if (bus.Q !== 16'h00B5) begin errors++; $display("FAIL shr_q: got %h expected %h", bus.Q, 16'h00B5); end
    apply(1'b1, 2'b00, 2'b00, 2'b00, 16'h0000);
    checks++;
    if (bus.FRM !== 1'b0) begin errors++; $display("FAIL shr_frm_drop: got %b expected %b", bus.FRM, 1'b0); end
  endtask

  task automatic test_cross_left;
    apply(1'b1, 2'b11, 2'b00, 2'b00, 16'h0100);
    apply(1'b1, 2'b10, 2'b11, 2'b00, 16'h0000);
    checks++;
    if (bus.Q !== 16'h0080) begin errors++; $display("FAIL shl_cross: got %h expected %h", bus.Q, 16'h0080); end
    apply(1'b1, 2'b10, 2'b00, 2'b11, 16'h0000);
    checks++;
    if (bus.Q !== 16'h8040) begin errors++; $display("FAIL shl_serial_in: got %h expected %h", bus.Q, 16'h8040); end
  endtask

  task automatic test_enable_hold;
    apply(1'b1, 2'b11, 2'b00, 2'b00, 16'hABCD);
    for (int i = 0; i < 3; i++) apply(1'b1, 2'b01, 2'b11, 2'b00, 16'h0000);
    checks++;
    if (bus.Q !== 16'h5E6F) begin errors++; $display("FAIL en_shift_q: got %h expected %h", bus.Q, 16'h5E6F); end
    for (int i = 0; i < 3; i++) apply(1'b0, 2'b01, 2'b11, 2'b11, 16'h0000);
    checks++;
    if (bus.Q !== 16'h5E6F) begin errors++; $display("FAIL ce0_hold_q: got %h expected %h", bus.Q, 16'h5E6F); end
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 2'b01, 2'b00, 2'b00, 16'h0000);
      checks++;
      if (bus.FRM !== (i == 4)) begin
        errors++; $display("FAIL ce0_cnt_hold_frm%0d: got %b expected %b", i, bus.FRM, (i == 4));
      end
    end
    apply(1'b1, 2'b00, 2'b00, 2'b00, 16'h0000);
    checks++;
    if (bus.FRM !== 1'b0) begin errors++; $display("FAIL hold_clr_frm: got %b expected %b", bus.FRM, 1'b0); end
    for (int i = 0; i < 5; i++) apply(1'b1, 2'b01, 2'b00, 2'b00, 16'h0000);
    apply(1'b1, 2'b11, 2'b00, 2'b00, 16'h1234);
    checks++;
    if (bus.Q !== 16'h1234) begin errors++; $display("FAIL load_q: got %h expected %h", bus.Q, 16'h1234); end
    checks++;
    if (bus.FRM !== 1'b0) begin errors++; $display("FAIL load_frm: got %b expected %b", bus.FRM, 1'b0); end
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 2'b10, 2'b00, 2'b00, 16'h0000);
      checks++;
      if (bus.FRM !== (i == 7)) begin
        errors++; $display("FAIL load_cnt_clr_frm%0d: got %b expected %b", i, bus.FRM, (i == 7));
      end
    end
    checks++;
    if (bus.Q !== 16'h0012) begin errors++; $display("FAIL shl8_q: got %h expected %h", bus.Q, 16'h0012); end
  endtask

  task automatic test_tap;
    logic [4:0] sel;
    apply(1'b1, 2'b11, 2'b00, 2'b00, 16'h8001);
    bus.TSEL = 5'd0; #1;
    checks++;
    if (bus.QT !== 1'b1) begin errors++; $display("FAIL tap0: got %b expected %b", bus.QT, 1'b1); end
    bus.TSEL = 5'd15; #1;
    checks++;
    if (bus.QT !== 1'b1) begin errors++; $display("FAIL tap15: got %b expected %b", bus.QT, 1'b1); end
    bus.TSEL = 5'd7; #1;
    checks++;
    if (bus.QT !== 1'b0) begin errors++; $display("FAIL tap7: got %b expected %b", bus.QT, 1'b0); end
    apply(1'b1, 2'b11, 2'b00, 2'b00, 16'hFFFF);
    for (int i = 16; i < 32; i++) begin
      sel = 5'(i);
      bus.TSEL = sel; #1;
      checks++;
      if (bus.QT !== 1'b0) begin errors++; $display("FAIL tap_oob%0d: got %b expected %b", i, bus.QT, 1'b0); end
    end
    bus.TSEL = 5'd9; #1;
    checks++;
    if (bus.QT !== 1'b1) begin errors++; $display("FAIL tap9: got %b expected %b", bus.QT, 1'b1); end
    bus.TSEL = 5'd0;
  endtask

  task automatic test_async_reset;
    apply(1'b1, 2'b11, 2'b00, 2'b00, 16'hA5C3);
    for (int i = 0; i < 3; i++) apply(1'b1, 2'b01, 2'b00, 2'b00, 16'h0000);
    #3;
    MRn = 1'b0;
    #1;
    checks++;
    if (bus.Q !== 16'h0000) begin errors++; $display("FAIL async_q: got %h expected %h", bus.Q, 16'h0000); end
    checks++;
    if (bus.FRM !== 1'b0) begin errors++; $display("FAIL async_frm: got %b expected %b", bus.FRM, 1'b0); end
    #1;
    MRn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 2'b01, 2'b11, 2'b00, 16'h0000);
      checks++;
      if (bus.FRM !== (i == 7)) begin
        errors++; $display("FAIL async_cnt_clr_frm%0d: got %b expected %b", i, bus.FRM, (i == 7));
      end
    end
    checks++;
    if (bus.Q !== 16'h00FF) begin errors++; $display("FAIL async_after_q: got %h expected %h", bus.Q, 16'h00FF); end
  endtask

`ifdef SHREG_PARITY_EN
  task automatic test_parity;
    apply(1'b1, 2'b11, 2'b00, 2'b00, 16'h0007);
    checks++;
    if (bus.PAR !== 1'b1) begin errors++; $display("FAIL par_load: got %b expected %b", bus.PAR, 1'b1); end
    apply(1'b1, 2'b01, 2'b00, 2'b00, 16'h0000);
    checks++;
    if (bus.Q !== 16'h000E) begin errors++; $display("FAIL par_shr_q: got %h expected %h", bus.Q, 16'h000E); end
    checks++;
    if (bus.PAR !== 1'b1) begin errors++; $display("FAIL par_shr: got %b expected %b", bus.PAR, 1'b1); end
    apply(1'b1, 2'b00, 2'b00, 2'b00, 16'h0000);
    checks++;
    if (bus.PAR !== 1'b1) begin errors++; $display("FAIL par_hold: got %b expected %b", bus.PAR, 1'b1); end
    apply(1'b1, 2'b11, 2'b00, 2'b00, 16'h0003);
    checks++;
    if (bus.PAR !== 1'b0) begin errors++; $display("FAIL par_load3: got %b expected %b", bus.PAR, 1'b0); end
    apply(1'b1, 2'b11, 2'b00, 2'b00, 16'h0001);
    #3;
    MRn = 1'b0;
    #1;
    checks++;
    if (bus.PAR !== 1'b0) begin errors++; $display("FAIL par_reset: got %b expected %b", bus.PAR, 1'b0); end
    #1;
    MRn = 1'b1;
  endtask
`endif

  initial begin
    checks   = 0;
    errors   = 0;
    MRn      = 1'b0;
    bus.CE   = 1'b0;
    bus.S    = 2'b00;
    bus.DSR  = 2'b00;
    bus.DSL  = 2'b00;
    bus.D    = 16'h0000;
    bus.TSEL = 5'd0;
    test_reset();
    test_shift_right();
    test_cross_left();
    test_enable_hold();
    test_tap();
    test_async_reset();
`ifdef SHREG_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
